// File: rtl/id_ex_operand_stage_pkg.sv
// Shared encodings for the ID/EX operand stage: forwarding select codes and the
// ALU opcode that a bubble carries.
package id_ex_operand_stage_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;

endpackage

// File: rtl/id_ex_operand_stage_forward_select.sv
// Per-source forwarding decision: MEM result beats WB result, and register 0
// never forwards.
module forward_select
  import id_ex_operand_stage_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] src,
  input  logic [RW-1:0] write_reg_m,
  input  logic [RW-1:0] write_reg_w,
  input  logic          reg_write_m,
  input  logic          reg_write_w,
  output fwd_sel_t      sel
);

  always_comb begin
    sel = FWD_REG;
    if (reg_write_m && (write_reg_m != '0) && (write_reg_m == src)) begin
      sel = FWD_M;
    end else if (reg_write_w && (write_reg_w != '0) && (write_reg_w == src)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with stall/flush, plus combinational MEM/WB operand
// forwarding feeding the ALU inputs and the store data path.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int AWL = 6,
  parameter int DWL = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [DWL-1:0]   RD1D,
  input  logic [DWL-1:0]   RD2D,
  input  logic [DWL-1:0]   ImmD,
  input  logic [AWL-2:0]   RsD,
  input  logic [AWL-2:0]   RtD,
  input  logic [AWL-2:0]   RdD,
  input  logic [AWL-2:0]   ShamtD,
  input  logic [AWL-3:0]   ALUSelD,
  input  logic             ALUSrcD,
  input  logic             RegDstD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             MemtoRegD,
  input  logic [DWL-1:0]   ALUOutM,
  input  logic [DWL-1:0]   ResultW,
  input  logic [AWL-2:0]   WriteRegM,
  input  logic [AWL-2:0]   WriteRegW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  output logic [DWL-1:0]   ALUIn1E,
  output logic [DWL-1:0]   ALUIn2E,
  output logic [AWL-2:0]   ShamtE,
  output logic [AWL-3:0]   ALUSelE,
  output logic [DWL-1:0]   WriteDataE,
  output logic [AWL-2:0]   WriteRegE,
  output logic [AWL-2:0]   RsE,
  output logic [AWL-2:0]   RtE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             MemtoRegE,
  output logic             ValidE
);

  localparam int RW = AWL - 1;
  localparam int SW = AWL - 2;

  logic [DWL-1:0] rd1_reg, rd2_reg, imm_reg;
  logic [RW-1:0]  rs_reg, rt_reg, rd_reg, shamt_reg;
  logic [SW-1:0]  alusel_reg;
  logic           alusrc_reg, regdst_reg, regwrite_reg, memwrite_reg, memtoreg_reg, valid_reg;

  // Flush shares the reset path so a bubble is indistinguishable from reset state.
  always_ff @(posedge CLK) begin
    if (RST || FlushE) begin
      rd1_reg      <= '0;
      rd2_reg      <= '0;
      imm_reg      <= '0;
      rs_reg       <= '0;
      rt_reg       <= '0;
      rd_reg       <= '0;
      shamt_reg    <= '0;
      alusel_reg   <= SW'(ALU_ADD);
      alusrc_reg   <= 1'b0;
      regdst_reg   <= 1'b0;
      regwrite_reg <= 1'b0;
      memwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      valid_reg    <= 1'b0;
    end else if (!StallE) begin
      rd1_reg      <= RD1D;
      rd2_reg      <= RD2D;
      imm_reg      <= ImmD;
      rs_reg       <= RsD;
      rt_reg       <= RtD;
      rd_reg       <= RdD;
      shamt_reg    <= ShamtD;
      alusel_reg   <= ALUSelD;
      alusrc_reg   <= ALUSrcD;
      regdst_reg   <= RegDstD;
      regwrite_reg <= RegWriteD;
      memwrite_reg <= MemWriteD;
      memtoreg_reg <= MemtoRegD;
      valid_reg    <= 1'b1;
    end
  end

  logic [RW-1:0]  src     [2];
  logic [DWL-1:0] reg_val [2];

  assign src[0]     = rs_reg;
  assign src[1]     = rt_reg;
  assign reg_val[0] = rd1_reg;
  assign reg_val[1] = rd2_reg;

  // Index 0 is operand A (rs), index 1 is operand B (rt).
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_sel_t       sel;
    logic [DWL-1:0] val;

    forward_select #(.RW(RW)) u_sel (
      .src         (src[gi]),
      .write_reg_m (WriteRegM),
      .write_reg_w (WriteRegW),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .sel         (sel)
    );

    assign val = (sel == FWD_M) ? ALUOutM :
                 (sel == FWD_W) ? ResultW : reg_val[gi];
  end

  assign ALUIn1E    = g_fwd[0].val;
  assign WriteDataE = g_fwd[1].val;
  assign ALUIn2E    = alusrc_reg ? imm_reg : g_fwd[1].val;
  assign WriteRegE  = regdst_reg ? rd_reg : rt_reg;
  assign ShamtE     = shamt_reg;
  assign ALUSelE    = alusel_reg;
  assign RsE        = rs_reg;
  assign RtE        = rt_reg;
  assign RegWriteE  = regwrite_reg;
  assign MemWriteE  = memwrite_reg;
  assign MemtoRegE  = memtoreg_reg;
  assign ValidE     = valid_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed plus randomized checks of the ID/EX operand stage against a
// behavioural model of the captured instruction and the forwarding rules.
module tb_id_ex_operand_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush;
  logic [31:0] rd1d, rd2d, immd, aluoutm, resultw;
  logic [4:0]  rsd, rtd, rdd, shamtd, wrm, wrw;
  logic [3:0]  alusel;
  logic        alusrc, regdst, rwd, mwd, m2rd, rwm, rww;

  logic [31:0] alu1, alu2, wdata;
  logic [4:0]  shamte, wrege, rse, rte;
  logic [3:0]  alusele;
  logic        rwe, mwe, m2re, vale;

  id_ex_operand_stage #(.AWL(6), .DWL(32)) dut (
    .CLK(clk), .RST(rst), .StallE(stall), .FlushE(flush),
    .RD1D(rd1d), .RD2D(rd2d), .ImmD(immd),
    .RsD(rsd), .RtD(rtd), .RdD(rdd), .ShamtD(shamtd), .ALUSelD(alusel),
    .ALUSrcD(alusrc), .RegDstD(regdst),
    .RegWriteD(rwd), .MemWriteD(mwd), .MemtoRegD(m2rd),
    .ALUOutM(aluoutm), .ResultW(resultw),
    .WriteRegM(wrm), .WriteRegW(wrw), .RegWriteM(rwm), .RegWriteW(rww),
    .ALUIn1E(alu1), .ALUIn2E(alu2), .ShamtE(shamte), .ALUSelE(alusele),
    .WriteDataE(wdata), .WriteRegE(wrege), .RsE(rse), .RtE(rte),
    .RegWriteE(rwe), .MemWriteE(mwe), .MemtoRegE(m2re), .ValidE(vale)
  );

  int total = 0;
  int bad   = 0;

  // Model of the instruction currently held in EX.
  logic [31:0] m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd, m_shamt;
  logic [3:0]  m_alusel;
  logic        m_alusrc, m_regdst, m_rw, m_mw, m_m2r, m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] regv);
    if (rwm && wrm != 0 && wrm == src) return aluoutm;
    if (rww && wrw != 0 && wrw == src) return resultw;
    return regv;
  endfunction

  task automatic check_all();
    chk("ALUIn1E",    alu1,   fwd(m_rs, m_rd1));
    chk("WriteDataE", wdata,  fwd(m_rt, m_rd2));
    chk("ALUIn2E",    alu2,   m_alusrc ? m_imm : fwd(m_rt, m_rd2));
    chk("ShamtE",     {27'd0, shamte}, {27'd0, m_shamt});
    chk("ALUSelE",    {28'd0, alusele}, {28'd0, m_alusel});
    chk("WriteRegE",  {27'd0, wrege}, {27'd0, (m_regdst ? m_rd : m_rt)});
    chk("RsE",        {27'd0, rse}, {27'd0, m_rs});
    chk("RtE",        {27'd0, rte}, {27'd0, m_rt});
    chk("ctrl",       {28'd0, rwe, mwe, m2re, vale}, {28'd0, m_rw, m_mw, m_m2r, m_valid});
  endtask

  task automatic step();
    if (rst || flush) begin
      {m_rd1, m_rd2, m_imm} = '0;
      {m_rs, m_rt, m_rd, m_shamt} = '0;
      m_alusel = 4'd0;
      {m_alusrc, m_regdst, m_rw, m_mw, m_m2r, m_valid} = '0;
    end else if (!stall) begin
      m_rd1 = rd1d; m_rd2 = rd2d; m_imm = immd;
      m_rs = rsd; m_rt = rtd; m_rd = rdd; m_shamt = shamtd; m_alusel = alusel;
      m_alusrc = alusrc; m_regdst = regdst;
      m_rw = rwd; m_mw = mwd; m_m2r = m2rd; m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rand_d();
    rd1d = $urandom; rd2d = $urandom; immd = $urandom;
    rsd = 5'($urandom_range(0, 3)); rtd = 5'($urandom_range(0, 3)); rdd = 5'($urandom);
    shamtd = 5'($urandom); alusel = 4'($urandom);
    alusrc = 1'($urandom); regdst = 1'($urandom);
    rwd = 1'($urandom); mwd = 1'($urandom); m2rd = 1'($urandom);
  endtask

  task automatic rand_fwd();
    aluoutm = $urandom; resultw = $urandom;
    wrm = 5'($urandom_range(0, 3)); wrw = 5'($urandom_range(0, 3));
    rwm = 1'($urandom); rww = 1'($urandom);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rwm = 1'b0; rww = 1'b0; wrm = '0; wrw = '0; aluoutm = '0; resultw = '0;
    rand_d();
    rd1d = 32'hDEAD_BEEF; rwd = 1'b1;

    // Reset with nonzero inputs
    step();
    step();
    chk("reset_valid", {31'd0, vale}, 32'd0);
    chk("reset_in1", alu1, 32'd0);
    rst = 1'b0;
    step();
    chk("release_valid", {31'd0, vale}, 32'd1);

    // Plain load, immediate operand
    rand_d();
    rd1d = 32'd5; rd2d = 32'd7; immd = 32'd100; alusrc = 1'b1;
    step();
    chk("load_in1", alu1, 32'd5);
    chk("load_in2", alu2, 32'd100);
    chk("load_wdata", wdata, 32'd7);

    // MEM vs WB priority
    rsd = 5'd3; rtd = 5'd3; alusrc = 1'b0;
    step();
    rwm = 1'b1; wrm = 5'd3; aluoutm = 32'hAA;
    rww = 1'b1; wrw = 5'd3; resultw = 32'hBB;
    #1;
    chk("fwd_mem_in1", alu1, 32'hAA);
    chk("fwd_mem_wdata", wdata, 32'hAA);
    rwm = 1'b0;
    #1;
    chk("fwd_wb_in1", alu1, 32'hBB);
    chk("fwd_wb_wdata", wdata, 32'hBB);
    chk("fwd_wb_in2", alu2, 32'hBB);

    // Register 0 never forwards
    rww = 1'b0;
    rsd = 5'd0; rd1d = 32'h1234;
    step();
    rwm = 1'b1; wrm = 5'd0; aluoutm = 32'hFF;
    #1;
    chk("r0_noforward", alu1, 32'h1234);
    rwm = 1'b0;

    // Stall holds through changing inputs
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_d();
      step();
      chk("stall_in1", alu1, 32'h1234);
    end
    rwd = 1'b1; mwd = 1'b1;
    flush = 1'b1;
    step();
    chk("bubble_ctrl", {29'd0, rwe, mwe, vale}, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Destination select
    rdd = 5'd9; rtd = 5'd4; regdst = 1'b1;
    step();
    chk("regdst_rd", {27'd0, wrege}, 32'd9);
    regdst = 1'b0;
    step();
    chk("regdst_rt", {27'd0, wrege}, 32'd4);

    // Reset during stall
    stall = 1'b1; rst = 1'b1;
    step();
    chk("rst_in_stall", {31'd0, vale}, 32'd0);
    rst = 1'b0; stall = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      rand_d();
      rand_fwd();
      stall = ($urandom_range(0, 99) < 25);
      flush = ($urandom_range(0, 99) < 10);
      rst   = ($urandom_range(0, 99) < 3);
      step();
      rand_fwd();
      #1;
      check_all();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
